mdu_seq: RTL and testbench

Iterative multiply/divide sequencer for the EX stage. It runs MULT/MULTU/DIV/DIVU over 32 iterations and produces the HI/LO pair. Every per-iteration add and subtract goes through an external 32-bit ALU port; the block only supplies control, operands and bookkeeping. The hazard logic holds the pipeline on `busy` and reads `hi`/`lo` after `done`.

---
 rtl/mdu_seq_pkg.sv | 24 ++
 rtl/mdu_seq_if.sv | 29 ++
 rtl/mdu_seq_signfix.sv | 14 +
 rtl/mdu_seq.sv | 157 +++++++++++++++
 tb/tb_mdu_seq.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_seq_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
// The ALU function codes match the shared EX-stage ALU encoding.
package mdu_pkg;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } mdu_op_t;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      ITER,
      FIX,
      DONE
   } mdu_state_t;

   localparam logic [3:0] ALU_F_ADD = 4'b0000;
   localparam logic [3:0] ALU_F_SUB = 4'b0001;
   localparam int         MDU_ITERS = 32;

endpackage

// File: rtl/mdu_seq_if.sv
// Request/result/ALU bundle between the EX stage (master) and mdu_seq (slave).
interface mdu_seq_if #(parameter int WIDTH = 32);
   import mdu_pkg::*;

   logic             start;
   mdu_op_t          op;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_by_zero;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [3:0]       alu_f;
   logic [WIDTH-1:0] alu_y;

   modport master (
      output start, op, rs_val, rt_val, alu_y,
      input  busy, done, hi, lo, div_by_zero, alu_a, alu_b, alu_f
   );

   modport slave (
      input  start, op, rs_val, rt_val, alu_y,
      output busy, done, hi, lo, div_by_zero, alu_a, alu_b, alu_f
   );

endinterface

// File: rtl/mdu_seq_signfix.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign restore.
module mdu_signfix
   import mdu_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         neg,
   input  logic [W-1:0] a,
   output logic [W-1:0] y
);

   assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/mdu_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer driving an external shared ALU.
// Signed operation is built only with MDU_SIGNED_EN; otherwise all ops run unsigned.
module mdu_seq
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   mdu_seq_if.slave  mif
);

   mdu_state_t         state, nstate;
   logic               is_div;
   logic [WIDTH-1:0]   rs_q, rt_q, dvs, p_hi, p_lo;
   logic [4:0]         cnt;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               dbz;
   logic [WIDTH-1:0]   rs_mag, rt_mag, q_fix, r_fix;
   logic [2*WIDTH-1:0] p_fix;
   logic [WIDTH:0]     rp;
   logic               take, carry;
   logic [WIDTH-1:0]   alu_a, alu_b;
   logic [3:0]         alu_f;

`ifdef MDU_SIGNED_EN
   logic sgn_op, sgn_x, sgn_r, rs_neg, rt_neg;

   assign rs_neg = sgn_op & rs_q[WIDTH-1];
   assign rt_neg = sgn_op & rt_q[WIDTH-1];

   mdu_signfix #(.W(WIDTH))   u_mag_rs (.neg(rs_neg), .a(rs_q),         .y(rs_mag));
   mdu_signfix #(.W(WIDTH))   u_mag_rt (.neg(rt_neg), .a(rt_q),         .y(rt_mag));
   mdu_signfix #(.W(2*WIDTH)) u_fix_p  (.neg(sgn_x),  .a({p_hi, p_lo}), .y(p_fix));
   mdu_signfix #(.W(WIDTH))   u_fix_q  (.neg(sgn_x),  .a(p_lo),         .y(q_fix));
   mdu_signfix #(.W(WIDTH))   u_fix_r  (.neg(sgn_r),  .a(p_hi),         .y(r_fix));
`else
   assign rs_mag = rs_q;
   assign rt_mag = rt_q;
   assign p_fix  = {p_hi, p_lo};
   assign q_fix  = p_lo;
   assign r_fix  = p_hi;
`endif

   // Restoring-divide step: R is never >= divisor between steps, so 32 bits of R suffice.
   always_comb begin
      rp    = {p_hi, p_lo[WIDTH-1]};
      take  = rp[WIDTH] | (rp[WIDTH-1:0] >= dvs);
      carry = (mif.alu_y < p_hi);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= nstate;
   end

   always_comb begin
      nstate = state;
      alu_a  = '0;
      alu_b  = '0;
      alu_f  = ALU_F_ADD;
      case (state)
         IDLE: if (mif.start) nstate = PREP;
         PREP: nstate = (is_div && rt_q == '0) ? FIX : ITER;
         ITER: begin
            if (is_div) begin
               alu_f = ALU_F_SUB;
               alu_a = rp[WIDTH-1:0];
               alu_b = dvs;
            end else if (p_lo[0]) begin
               alu_a = p_hi;
               alu_b = dvs;
            end
            if (cnt == '0) nstate = FIX;
         end
         FIX:     nstate = DONE;
         DONE:    nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         is_div <= 1'b0;
         rs_q   <= '0;
         rt_q   <= '0;
         dvs    <= '0;
         p_hi   <= '0;
         p_lo   <= '0;
         cnt    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         dbz    <= 1'b0;
`ifdef MDU_SIGNED_EN
         sgn_op <= 1'b0;
         sgn_x  <= 1'b0;
         sgn_r  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (mif.start) begin
               is_div <= mif.op[1];
               rs_q   <= mif.rs_val;
               rt_q   <= mif.rt_val;
               dbz    <= 1'b0;
`ifdef MDU_SIGNED_EN
               sgn_op <= mif.op[0];
`endif
            end
            PREP: begin
               cnt  <= 5'(MDU_ITERS - 1);
               p_hi <= '0;
               p_lo <= is_div ? rs_mag : rt_mag;
               dvs  <= is_div ? rt_mag : rs_mag;
               if (is_div && rt_q == '0) dbz <= 1'b1;
`ifdef MDU_SIGNED_EN
               sgn_x <= rs_neg ^ rt_neg;
               sgn_r <= rs_neg;
`endif
            end
            ITER: begin
               cnt <= cnt - 5'd1;
               if (is_div) begin
                  p_hi <= take ? mif.alu_y : rp[WIDTH-1:0];
                  p_lo <= {p_lo[WIDTH-2:0], take};
               end else if (p_lo[0]) begin
                  {p_hi, p_lo} <= {carry, mif.alu_y, p_lo[WIDTH-1:1]};
               end else begin
                  {p_hi, p_lo} <= {1'b0, p_hi, p_lo[WIDTH-1:1]};
               end
            end
            FIX: begin
               if (dbz) begin
                  hi_q <= rs_q;
                  lo_q <= '1;
               end else if (is_div) begin
                  hi_q <= r_fix;
                  lo_q <= q_fix;
               end else begin
                  {hi_q, lo_q} <= p_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign mif.busy        = (state != IDLE);
   assign mif.done        = (state == DONE);
   assign mif.hi          = hi_q;
   assign mif.lo          = lo_q;
   assign mif.div_by_zero = dbz;
   assign mif.alu_a       = alu_a;
   assign mif.alu_b       = alu_b;
   assign mif.alu_f       = alu_f;

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: directed cases plus random ops against an arithmetic reference model.
module tb_mdu_seq;
   import mdu_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   nvec = 0;
   int   nfail = 0;
   logic [31:0] prev_hi, prev_lo;

   always #5 clk = ~clk;

   mdu_seq_if #(.WIDTH(32)) mif ();

   mdu_seq #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .mif   (mif)
   );

   // Shared ALU as the parent would provide it
   assign mif.alu_y = (mif.alu_f == ALU_F_SUB) ? (mif.alu_a - mif.alu_b) : (mif.alu_a + mif.alu_b);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l, output logic z);
      bit sg;
      longint sa, sb, sp, q, r;
`ifdef MDU_SIGNED_EN
      sg = o[0];
`else
      sg = 1'b0;
`endif
      if (sg) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'(a);
         sb = longint'(b);
      end
      z = 1'b0;
      h = '0;
      l = '0;
      if (!o[1]) begin
         sp = sa * sb;
         h  = sp[63:32];
         l  = sp[31:0];
      end else if (b == 32'd0) begin
         z = 1'b1;
         h = a;
         l = 32'hFFFF_FFFF;
      end else begin
         q = sa / sb;
         r = sa % sb;
         l = q[31:0];
         h = r[31:0];
      end
   endfunction

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit poke);
      logic [31:0] eh, el;
      logic        ez;
      int          cyc;
      bit          seen;
      model(o, a, b, eh, el, ez);
      @(negedge clk);
      mif.start  = 1'b1;
      mif.op     = mdu_op_t'(o);
      mif.rs_val = a;
      mif.rt_val = b;
      @(posedge clk); #1;
      mif.start = 1'b0;
      cyc = 1;
      chk("busy_prep", 32'(mif.busy), 32'd1);
      chk("dbz_clear", 32'(mif.div_by_zero), 32'd0);
      chk("hi_hold", mif.hi, prev_hi);
      chk("lo_hold", mif.lo, prev_lo);
      seen = 1'b0;
      while (!seen && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         if (poke && cyc == 12) begin
            mif.start  = 1'b1;
            mif.op     = OP_DIVU;
            mif.rs_val = $urandom;
            mif.rt_val = 32'd3;
         end
         if (poke && cyc == 13) mif.start = 1'b0;
         if (mif.done) seen = 1'b1;
         else if (poke) chk("busy_iter", 32'(mif.busy), 32'd1);
      end
      chk("latency", 32'(cyc), ez ? 32'd3 : 32'd35);
      chk("hi", mif.hi, eh);
      chk("lo", mif.lo, el);
      chk("dbz", 32'(mif.div_by_zero), 32'(ez));
      @(posedge clk); #1;
      chk("done_pulse", 32'(mif.done), 32'd0);
      chk("busy_idle", 32'(mif.busy), 32'd0);
      prev_hi = eh;
      prev_lo = el;
   endtask

   initial begin
      int cyc, ndone;
      logic [1:0]  o;
      logic [31:0] a, b;

      rst_n      = 1'b0;
      mif.start  = 1'b0;
      mif.op     = OP_MULTU;
      mif.rs_val = '0;
      mif.rt_val = '0;
      prev_hi    = '0;
      prev_lo    = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(mif.busy), 32'd0);
      chk("rst_done", 32'(mif.done), 32'd0);
      chk("rst_dbz", 32'(mif.div_by_zero), 32'd0);
      chk("rst_hi", mif.hi, 32'd0);
      chk("rst_lo", mif.lo, 32'd0);
      chk("rst_alu_a", mif.alu_a, 32'd0);
      chk("rst_alu_b", mif.alu_b, 32'd0);
      chk("rst_alu_f", 32'(mif.alu_f), 32'(ALU_F_ADD));
      @(negedge clk);
      rst_n = 1'b1;

      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      chk("multu_max_hi", mif.hi, 32'hFFFF_FFFE);
      chk("multu_max_lo", mif.lo, 32'h0000_0001);

      run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0);
`ifdef MDU_SIGNED_EN
      chk("mult_neg_hi", mif.hi, 32'hFFFF_FFFF);
`else
      chk("mult_neg_hi", mif.hi, 32'h0000_0006);
`endif
      chk("mult_neg_lo", mif.lo, 32'hFFFF_FFEB);

      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
`ifdef MDU_SIGNED_EN
      chk("div_neg_lo", mif.lo, 32'hFFFF_FFFD);
      chk("div_neg_hi", mif.hi, 32'hFFFF_FFFF);
`endif

      run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
`ifdef MDU_SIGNED_EN
      chk("div_ovf_lo", mif.lo, 32'h8000_0000);
      chk("div_ovf_hi", mif.hi, 32'h0000_0000);
`endif

      run_op(2'b10, 32'd100, 32'd0, 1'b0);
      chk("dbz_hi", mif.hi, 32'd100);
      chk("dbz_lo", mif.lo, 32'hFFFF_FFFF);
      chk("dbz_sticky", 32'(mif.div_by_zero), 32'd1);

      // A start arriving mid-ITER must not disturb the running op
      run_op(2'b00, 32'd123_457, 32'd98_765, 1'b1);
      run_op(2'b10, 32'hDEAD_BEEF, 32'd1234, 1'b1);

      // Reset at iteration 10 of MULTU 5x5
      @(negedge clk);
      mif.start  = 1'b1;
      mif.op     = OP_MULTU;
      mif.rs_val = 32'd5;
      mif.rt_val = 32'd5;
      @(posedge clk); #1;
      mif.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("midrst_busy", 32'(mif.busy), 32'd0);
      chk("midrst_done", 32'(mif.done), 32'd0);
      chk("midrst_hi", mif.hi, 32'd0);
      chk("midrst_lo", mif.lo, 32'd0);
      chk("midrst_dbz", 32'(mif.div_by_zero), 32'd0);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (mif.done || mif.busy) ndone++;
      end
      chk("midrst_quiet", 32'(ndone), 32'd0);
      prev_hi = '0;
      prev_lo = '0;
      run_op(2'b00, 32'd5, 32'd5, 1'b0);
      chk("after_rst_lo", mif.lo, 32'd25);

      // start together with reset is dropped
      @(negedge clk);
      mif.start = 1'b1;
      rst_n     = 1'b0;
      @(posedge clk); #1;
      mif.start = 1'b0;
      rst_n     = 1'b1;
      chk("rst_start_busy0", 32'(mif.busy), 32'd0);
      @(posedge clk); #1;
      chk("rst_start_busy1", 32'(mif.busy), 32'd0);
      prev_hi = '0;
      prev_lo = '0;

      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
            default: b = $urandom;
         endcase
         if (i % 5 == 0) a = 32'h8000_0000;
         run_op(o, a, b, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
